// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        F_IDLE    = 2'd0,
        F_REQ     = 2'd1,
        F_WAIT    = 2'd2,
        F_DISCARD = 2'd3
    } fetch_state_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries; flush beats push and pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    // Popping an empty queue is silently ignored.
    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instruction_prefetch.sv
// Sequential instruction fetcher feeding a prefetch queue, with redirect flush
// and squashing of a bus read that was already in flight.
module instruction_prefetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in_BUS,
    input  logic              bus_full,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              instr_ready_i,
    output logic              bus_read_o,
    output logic [ADDR_W-1:0] address_out,
    output logic              instr_valid_o,
    output logic [DATA_W-1:0] instruction_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output fetch_state_t      state
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_X = (CNT_W + 1)'(DEPTH);

    fetch_state_t             state_q, state_d;
    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic [ADDR_W-1:0]        addr_q;
    logic [ADDR_W-1:0]        redirect_target;
    logic                     push, pop;
    logic [CNT_W-1:0]         fifo_count;
    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic [CNT_W:0]           count_ext, count_after;

    assign redirect_target = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign pop             = instr_valid_o & instr_ready_i;
    assign count_ext       = {1'b0, fifo_count};
    assign count_after     = count_ext + (CNT_W + 1)'(1) - (CNT_W + 1)'(pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        unique case (state_q)
            F_IDLE: begin
                if (redirect_i) begin
                    pc_d    = redirect_target;
                    state_d = F_REQ;
                end else if (count_ext < DEPTH_X) begin
                    state_d = F_REQ;
                end
            end
            F_REQ: begin
                if (redirect_i) begin
                    pc_d    = redirect_target;
                    state_d = F_DISCARD;
                end else begin
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                // A redirect coinciding with completion drops the word immediately.
                if (redirect_i) begin
                    pc_d    = redirect_target;
                    state_d = bus_full ? F_DISCARD : F_REQ;
                end else if (!bus_full) begin
                    push    = 1'b1;
                    pc_d    = pc_q + ADDR_W'(PC_STEP);
                    state_d = (count_after < DEPTH_X) ? F_REQ : F_IDLE;
                end
            end
            F_DISCARD: begin
                if (redirect_i)
                    pc_d = redirect_target;
                if (!bus_full)
                    state_d = F_REQ;
            end
            default: state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= F_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Latched at issue so the bus address survives a redirect mid-transaction.
    always_ff @(posedge clk) begin
        if (state_q == F_REQ)
            addr_q <= pc_q;
    end

    fetch_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   ({addr_q, data_in_BUS}),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign state         = state_q;
    assign bus_read_o    = (state_q != F_IDLE);
    assign address_out   = (state_q == F_IDLE) ? '0 :
                           (state_q == F_REQ)  ? pc_q : addr_q;
    assign instr_valid_o = (fifo_count != '0);
    assign instruction_o = instr_valid_o ? fifo_head[DATA_W-1:0] : '0;
    assign instr_pc_o    = instr_valid_o ? fifo_head[ADDR_W+DATA_W-1:DATA_W] : '0;

endmodule
